// File: rtl/cog_segment_accumulator_if.sv
// Output record stream of cog_segment_accumulator (valid/ready, first-word-fall-through).
// Peak fields exist only when COG_SEG_PEAK_EN is defined.
interface cog_segment_accumulator_if #(
    parameter int DATA_WIDTH = 8
);
    logic                    m_seg_valid;
    logic                    m_seg_ready;
    logic [10:0]             m_seg_line;
    logic [10:0]             m_seg_start;
    logic [10:0]             m_seg_len;
    logic [DATA_WIDTH+10:0]  m_seg_sum_i;
    logic [DATA_WIDTH+21:0]  m_seg_sum_ix;
    logic                    m_seg_eof;
`ifdef COG_SEG_PEAK_EN
    logic [DATA_WIDTH-1:0]   m_seg_peak;
    logic [10:0]             m_seg_peak_x;

    modport master (
        output m_seg_valid, m_seg_line, m_seg_start, m_seg_len,
               m_seg_sum_i, m_seg_sum_ix, m_seg_eof, m_seg_peak, m_seg_peak_x,
        input  m_seg_ready
    );
    modport slave (
        input  m_seg_valid, m_seg_line, m_seg_start, m_seg_len,
               m_seg_sum_i, m_seg_sum_ix, m_seg_eof, m_seg_peak, m_seg_peak_x,
        output m_seg_ready
    );
`else
    modport master (
        output m_seg_valid, m_seg_line, m_seg_start, m_seg_len,
               m_seg_sum_i, m_seg_sum_ix, m_seg_eof,
        input  m_seg_ready
    );
    modport slave (
        input  m_seg_valid, m_seg_line, m_seg_start, m_seg_len,
               m_seg_sum_i, m_seg_sum_ix, m_seg_eof,
        output m_seg_ready
    );
`endif
endinterface

// File: rtl/cog_segment_accumulator.sv
// Accumulates per-run pixel count, sum I and sum I*x from the CoG figure stream and queues
// one record per run. Define COG_SEG_PEAK_EN to also track the per-run peak and its x.
module cog_segment_accumulator #(
    parameter int DATA_WIDTH = 8,
    parameter int WIDTH      = 1280,
    parameter int HEIGHT     = 1024,
    parameter int MIN_LEN    = 3,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  i_sys_clk,
    input  logic                  i_sys_aresetn,
    input  logic [DATA_WIDTH-1:0] i_data_image,
    input  logic                  i_data_valid,
    input  logic [10:0]           i_start_point,
    input  logic                  i_start_of_fig,
    input  logic                  i_end_of_fig,
    input  logic                  i_end_of_line,
    input  logic                  i_end_of_frame,
    input  logic                  i_new_frame,
    cog_segment_accumulator_if.master seg,
    output logic                  o_overflow,
    output logic                  o_proto_err
);
    localparam int SI_W  = DATA_WIDTH + 11;
    localparam int SIX_W = DATA_WIDTH + 22;
    localparam int AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW    = AW + 1;
    localparam logic [10:0] X_MAX = 11'(WIDTH - 1);
    localparam logic [10:0] H_MAX = 11'(HEIGHT - 1);
    localparam logic [10:0] MIN_L = 11'(MIN_LEN);

    typedef enum logic [2:0] {IDLE, WAIT_SEG, ACCUM, PUSH, EOF_MARK} state_t;

    typedef struct packed {
        logic [10:0]       line;
        logic [10:0]       start;
        logic [10:0]       len;
        logic [SI_W-1:0]   sum_i;
        logic [SIX_W-1:0]  sum_ix;
        logic              eof;
`ifdef COG_SEG_PEAK_EN
        logic [DATA_WIDTH-1:0] peak;
        logic [10:0]           peak_x;
`endif
    } rec_t;

    state_t state, state_n;

    logic [10:0]      x, start, len, seg_line, line_cnt;
    logic [SI_W-1:0]  sum_i;
    logic [SIX_W-1:0] sum_ix;
    logic             eof_pend;
`ifdef COG_SEG_PEAK_EN
    logic [DATA_WIDTH-1:0] peak;
    logic [10:0]           peak_x;
`endif

    logic load, accum, push_req, push_eof, clr_frame, set_perr, eof_set;
    logic [DATA_WIDTH-1:0] pix;
    logic [10:0]           x_mul;
    logic [SI_W-1:0]       prod;

    rec_t                  mem [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] vld;
    logic [CW-1:0]         cnt;
    logic [AW-1:0]         wr_idx;
    logic                  pop, can_push, fifo_wr;
    rec_t                  wr_rec;

    always_ff @(posedge i_sys_clk or negedge i_sys_aresetn) begin
        if (!i_sys_aresetn) state <= IDLE;
        else                state <= state_n;
    end

    // A new_frame strobe always wins; outside IDLE it is an abort that skips the eof marker.
    always_comb begin
        state_n   = state;
        load      = 1'b0;
        accum     = 1'b0;
        push_req  = 1'b0;
        push_eof  = 1'b0;
        clr_frame = 1'b0;
        set_perr  = 1'b0;
        eof_set   = 1'b0;
        if (i_new_frame) begin
            clr_frame = 1'b1;
            state_n   = WAIT_SEG;
            set_perr  = (state != IDLE);
        end else begin
            case (state)
                IDLE: ;
                WAIT_SEG: begin
                    if (i_end_of_frame) begin
                        state_n = EOF_MARK;
                    end else begin
                        if (i_end_of_fig && !i_start_of_fig) set_perr = 1'b1;
                        if (i_start_of_fig && i_data_valid) begin
                            load    = 1'b1;
                            state_n = i_end_of_fig ? PUSH : ACCUM;
                        end
                    end
                end
                ACCUM: begin
                    eof_set = i_end_of_frame;
                    if (i_start_of_fig) begin
                        set_perr = 1'b1;
                        load     = 1'b1;
                        state_n  = i_end_of_fig ? PUSH : ACCUM;
                    end else begin
                        accum = i_data_valid;
                        if (i_end_of_fig) state_n = PUSH;
                    end
                end
                PUSH: begin
                    eof_set  = i_end_of_frame;
                    push_req = (len >= MIN_L);
                    state_n  = (eof_pend || i_end_of_frame) ? EOF_MARK : WAIT_SEG;
                end
                EOF_MARK: begin
                    push_eof = 1'b1;
                    if (can_push) state_n = IDLE;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    assign pix   = i_data_valid ? i_data_image : '0;
    assign x_mul = load ? i_start_point : x;
    assign prod  = SI_W'(pix) * SI_W'(x_mul);

    // x always points at the position of the next pixel to arrive.
    always_ff @(posedge i_sys_clk or negedge i_sys_aresetn) begin
        if (!i_sys_aresetn) begin
            x        <= '0;
            start    <= '0;
            len      <= '0;
            sum_i    <= '0;
            sum_ix   <= '0;
            seg_line <= '0;
`ifdef COG_SEG_PEAK_EN
            peak     <= '0;
            peak_x   <= '0;
`endif
        end else if (load) begin
            x        <= (i_data_valid && i_start_point != X_MAX) ? i_start_point + 11'd1 : i_start_point;
            start    <= i_start_point;
            len      <= {10'd0, i_data_valid};
            sum_i    <= SI_W'(pix);
            sum_ix   <= SIX_W'(prod);
            seg_line <= line_cnt;
`ifdef COG_SEG_PEAK_EN
            peak     <= pix;
            peak_x   <= i_start_point;
`endif
        end else if (accum) begin
            x      <= (x == X_MAX) ? x : x + 11'd1;
            len    <= len + 11'd1;
            sum_i  <= sum_i + SI_W'(pix);
            sum_ix <= sum_ix + SIX_W'(prod);
`ifdef COG_SEG_PEAK_EN
            if (i_data_image > peak) begin
                peak   <= i_data_image;
                peak_x <= x;
            end
`endif
        end
    end

    // The run's line is captured at its start, so end_of_line may advance line_cnt at once.
    always_ff @(posedge i_sys_clk or negedge i_sys_aresetn) begin
        if (!i_sys_aresetn) begin
            line_cnt    <= '0;
            eof_pend    <= 1'b0;
            o_overflow  <= 1'b0;
            o_proto_err <= 1'b0;
        end else begin
            if (clr_frame)
                line_cnt <= '0;
            else if (i_end_of_line && state != IDLE && line_cnt != H_MAX)
                line_cnt <= line_cnt + 11'd1;

            if (clr_frame || state == EOF_MARK) eof_pend <= 1'b0;
            else if (eof_set)                   eof_pend <= 1'b1;

            if (clr_frame)                   o_overflow <= 1'b0;
            else if (push_req && !can_push)  o_overflow <= 1'b1;

            if (set_perr)       o_proto_err <= 1'b1;
            else if (clr_frame) o_proto_err <= 1'b0;
        end
    end

    always_comb begin
        wr_rec = '0;
        if (push_eof) begin
            wr_rec.line = line_cnt;
            wr_rec.eof  = 1'b1;
        end else begin
            wr_rec.line   = seg_line;
            wr_rec.start  = start;
            wr_rec.len    = len;
            wr_rec.sum_i  = sum_i;
            wr_rec.sum_ix = sum_ix;
`ifdef COG_SEG_PEAK_EN
            wr_rec.peak   = peak;
            wr_rec.peak_x = peak_x;
`endif
        end
    end

    always_comb begin
        cnt = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) cnt = cnt + CW'(vld[i]);
    end

    assign pop      = vld[0] && seg.m_seg_ready;
    assign can_push = !vld[FIFO_DEPTH-1] || pop;
    assign fifo_wr  = (push_req || push_eof) && can_push;
    assign wr_idx   = AW'(cnt - CW'(pop));

    // Shift-register FIFO: entry 0 is the head and drives the outputs straight from flops.
    always_ff @(posedge i_sys_clk or negedge i_sys_aresetn) begin
        if (!i_sys_aresetn) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
            vld <= '0;
        end else begin
            if (pop) begin
                for (int i = 0; i < FIFO_DEPTH - 1; i++) mem[i] <= mem[i+1];
                vld <= {1'b0, vld[FIFO_DEPTH-1:1]};
            end
            if (fifo_wr) begin
                mem[wr_idx] <= wr_rec;
                vld[wr_idx] <= 1'b1;
            end
        end
    end

    assign seg.m_seg_valid  = vld[0];
    assign seg.m_seg_line   = mem[0].line;
    assign seg.m_seg_start  = mem[0].start;
    assign seg.m_seg_len    = mem[0].len;
    assign seg.m_seg_sum_i  = mem[0].sum_i;
    assign seg.m_seg_sum_ix = mem[0].sum_ix;
    assign seg.m_seg_eof    = mem[0].eof;
`ifdef COG_SEG_PEAK_EN
    assign seg.m_seg_peak   = mem[0].peak;
    assign seg.m_seg_peak_x = mem[0].peak_x;
`endif

endmodule

// File: tb/tb_cog_segment_accumulator.sv
// Directed self-checking bench for cog_segment_accumulator: vector table of runs plus
// hand-written stall/overflow, end-of-frame, protocol-error and async-reset sequences.
module tb_cog_segment_accumulator;

    typedef struct packed {
        logic [10:0] line;
        logic [10:0] start;
        logic [10:0] len;
        logic [18:0] sum_i;
        logic [29:0] sum_ix;
        logic        eof;
    } rec_t;

    typedef logic [7:0] pix_arr_t [0:4];

    typedef struct {
        logic [10:0] start;
        int          n;
        pix_arr_t    pix;
        bit          eol;
        bit          has_rec;
        rec_t        exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  data_image = '0;
    logic        data_valid = 1'b0;
    logic [10:0] start_point = '0;
    logic        start_of_fig = 1'b0;
    logic        end_of_fig = 1'b0;
    logic        end_of_line = 1'b0;
    logic        end_of_frame = 1'b0;
    logic        new_frame = 1'b0;
    logic        overflow, proto_err;

    int   checks = 0;
    int   errors = 0;
    rec_t got_q[$];
    rec_t exp_q[$];
    rec_t mon_rec;
    rec_t prev_rec;
    bit   prev_stall = 1'b0;
    vec_t vecs[7];

    cog_segment_accumulator_if #(.DATA_WIDTH(8)) seg_if ();

    cog_segment_accumulator dut (
        .i_sys_clk      (clk),
        .i_sys_aresetn  (rst_n),
        .i_data_image   (data_image),
        .i_data_valid   (data_valid),
        .i_start_point  (start_point),
        .i_start_of_fig (start_of_fig),
        .i_end_of_fig   (end_of_fig),
        .i_end_of_line  (end_of_line),
        .i_end_of_frame (end_of_frame),
        .i_new_frame    (new_frame),
        .seg            (seg_if),
        .o_overflow     (overflow),
        .o_proto_err    (proto_err)
    );

    always #5 clk = ~clk;

    function automatic rec_t mkRec(input int line, input int start, input int len,
                                   input int si, input int six, input int eof);
        rec_t r;
        r.line   = 11'(line);
        r.start  = 11'(start);
        r.len    = 11'(len);
        r.sum_i  = 19'(si);
        r.sum_ix = 30'(six);
        r.eof    = 1'(eof);
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    // Inputs change 2 time units after a rising edge; returns 2 units after the next edge.
    task automatic applyStimulus(input bit v, input logic [7:0] d, input bit sof, input bit eofig,
                                 input logic [10:0] sp, input bit eol, input bit eofr, input bit nf);
        data_valid   = v;
        data_image   = d;
        start_of_fig = sof;
        end_of_fig   = eofig;
        start_point  = sp;
        end_of_line  = eol;
        end_of_frame = eofr;
        new_frame    = nf;
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) applyStimulus(0, 8'd0, 0, 0, 11'd0, 0, 0, 0);
    endtask

    task automatic sendRun(input logic [10:0] sp, input int n, input pix_arr_t pix, input bit eol);
        for (int k = 0; k < n; k++)
            applyStimulus(1, pix[k], k == 0, k == n - 1, sp, eol && (k == n - 1), 0, 0);
    endtask

    task automatic compareQueues(input string tag);
        checkOutput({tag, "_count"}, 128'(got_q.size()), 128'(exp_q.size()));
        for (int k = 0; k < got_q.size() && k < exp_q.size(); k++)
            checkOutput($sformatf("%s_rec%0d", tag, k), 128'(got_q[k]), 128'(exp_q[k]));
        got_q.delete();
        exp_q.delete();
    endtask

    // Pops happen on the edge after a negedge that sees valid && ready.
    always @(negedge clk) begin
        if (rst_n && seg_if.m_seg_valid) begin
            mon_rec = mkRec(seg_if.m_seg_line, seg_if.m_seg_start, seg_if.m_seg_len,
                            seg_if.m_seg_sum_i, seg_if.m_seg_sum_ix, seg_if.m_seg_eof);
            if (prev_stall) checkOutput("stall_stable", 128'(mon_rec), 128'(prev_rec));
            if (seg_if.m_seg_ready) got_q.push_back(mon_rec);
            prev_stall = !seg_if.m_seg_ready;
            prev_rec   = mon_rec;
        end else begin
            prev_stall = 1'b0;
        end
    end

    initial begin
        vecs[0] = '{11'd100,  3, '{8'd10, 8'd20, 8'd30, 8'd0, 8'd0},   1'b0, 1'b1, mkRec(0, 100, 3, 60, 6080, 0)};
        vecs[1] = '{11'd200,  2, '{8'd50, 8'd60, 8'd0, 8'd0, 8'd0},    1'b0, 1'b0, mkRec(0, 0, 0, 0, 0, 0)};
        vecs[2] = '{11'd10,   4, '{8'd1, 8'd2, 8'd3, 8'd4, 8'd0},      1'b1, 1'b1, mkRec(0, 10, 4, 10, 120, 0)};
        vecs[3] = '{11'd5,    3, '{8'd7, 8'd7, 8'd7, 8'd0, 8'd0},      1'b0, 1'b1, mkRec(1, 5, 3, 21, 126, 0)};
        vecs[4] = '{11'd1277, 3, '{8'd255, 8'd255, 8'd255, 8'd0, 8'd0}, 1'b0, 1'b1, mkRec(1, 1277, 3, 765, 977670, 0)};
        vecs[5] = '{11'd50,   1, '{8'd9, 8'd0, 8'd0, 8'd0, 8'd0},      1'b0, 1'b0, mkRec(0, 0, 0, 0, 0, 0)};
        vecs[6] = '{11'd0,    5, '{8'd1, 8'd0, 8'd2, 8'd0, 8'd3},      1'b1, 1'b1, mkRec(1, 0, 5, 6, 16, 0)};

        seg_if.m_seg_ready = 1'b1;
        #3;
        checkOutput("rst_valid",    128'(seg_if.m_seg_valid),  128'(0));
        checkOutput("rst_overflow", 128'(overflow),            128'(0));
        checkOutput("rst_proto",    128'(proto_err),           128'(0));
        checkOutput("rst_sum_ix",   128'(seg_if.m_seg_sum_ix), 128'(0));
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #2;

        applyStimulus(0, 8'd0, 0, 0, 11'd0, 0, 0, 1);
        for (int i = 0; i < 7; i++) begin
            sendRun(vecs[i].start, vecs[i].n, vecs[i].pix, vecs[i].eol);
            if (i == 0) checkOutput("lat_push_cycle", 128'(seg_if.m_seg_valid), 128'(0));
            idle(1);
            if (i == 0) checkOutput("lat_valid_n2", 128'(seg_if.m_seg_valid), 128'(1));
            idle(2);
            if (vecs[i].has_rec) exp_q.push_back(vecs[i].exp);
        end
        idle(3);
        compareQueues("table");
        checkOutput("table_overflow", 128'(overflow),  128'(0));
        checkOutput("table_proto",    128'(proto_err), 128'(0));

        seg_if.m_seg_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            pix_arr_t p;
            int s;
            s = 20 * k + 10;
            p = '{8'(k + 1), 8'(k + 1), 8'(k + 1), 8'd0, 8'd0};
            sendRun(11'(s), 3, p, 1'b0);
            idle(2);
            if (k < 4) exp_q.push_back(mkRec(2, s, 3, 3 * (k + 1), (k + 1) * (3 * s + 3), 0));
        end
        checkOutput("stall_overflow", 128'(overflow),           128'(1));
        checkOutput("stall_valid",    128'(seg_if.m_seg_valid), 128'(1));
        seg_if.m_seg_ready = 1'b1;
        idle(8);
        compareQueues("stall");
        checkOutput("drain_valid", 128'(seg_if.m_seg_valid), 128'(0));

        applyStimulus(1, 8'd1, 1, 0, 11'd400, 0, 0, 0);
        applyStimulus(1, 8'd1, 0, 0, 11'd0,   0, 1, 0);
        applyStimulus(1, 8'd1, 0, 0, 11'd0,   0, 0, 0);
        applyStimulus(1, 8'd1, 0, 1, 11'd0,   0, 0, 0);
        idle(3);
        exp_q.push_back(mkRec(2, 400, 4, 4, 1606, 0));
        exp_q.push_back(mkRec(2, 0, 0, 0, 0, 1));
        applyStimulus(1, 8'd9, 1, 0, 11'd500, 0, 0, 0);
        applyStimulus(1, 8'd9, 0, 0, 11'd0,   0, 0, 0);
        applyStimulus(1, 8'd9, 0, 1, 11'd0,   0, 0, 0);
        idle(3);
        checkOutput("idle_ignored_valid", 128'(seg_if.m_seg_valid), 128'(0));
        compareQueues("eof");

        applyStimulus(0, 8'd0, 0, 0, 11'd0, 0, 0, 1);
        checkOutput("nf_clears_overflow", 128'(overflow),  128'(0));
        checkOutput("nf_proto",           128'(proto_err), 128'(0));

        seg_if.m_seg_ready = 1'b0;
        applyStimulus(1, 8'd9, 1, 0, 11'd250, 0, 0, 0);
        applyStimulus(1, 8'd9, 0, 0, 11'd0,   0, 0, 0);
        applyStimulus(1, 8'd5, 1, 0, 11'd300, 0, 0, 0);
        applyStimulus(1, 8'd5, 0, 0, 11'd0,   0, 0, 0);
        applyStimulus(1, 8'd5, 0, 1, 11'd0,   0, 0, 0);
        idle(2);
        checkOutput("perr_flag",   128'(proto_err), 128'(1));
        checkOutput("perr_valid",  128'(seg_if.m_seg_valid), 128'(1));
        checkOutput("perr_record", 128'(mkRec(seg_if.m_seg_line, seg_if.m_seg_start, seg_if.m_seg_len,
                                              seg_if.m_seg_sum_i, seg_if.m_seg_sum_ix, seg_if.m_seg_eof)),
                                   128'(mkRec(0, 300, 3, 15, 4515, 0)));

        applyStimulus(1, 8'd7, 1, 0, 11'd600, 0, 0, 0);
        applyStimulus(1, 8'd7, 0, 0, 11'd0,   0, 0, 0);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("arst_valid",  128'(seg_if.m_seg_valid), 128'(0));
        checkOutput("arst_proto",  128'(proto_err),          128'(0));
        checkOutput("arst_fields", 128'(mkRec(seg_if.m_seg_line, seg_if.m_seg_start, seg_if.m_seg_len,
                                              seg_if.m_seg_sum_i, seg_if.m_seg_sum_ix, seg_if.m_seg_eof)),
                                   128'(0));
        checkOutput("arst_overflow", 128'(overflow), 128'(0));
        idle(2);
        rst_n = 1'b1;
        idle(2);
        checkOutput("post_rst_valid", 128'(seg_if.m_seg_valid), 128'(0));
        checkOutput("post_rst_got", 128'(got_q.size()), 128'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
